// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the integer execute stage: widths, op-code table
// and the bundle produced by the combinational compute core.
package alu_exec_unit_pkg;

    localparam int ROB_BIT = 5;
    localparam int XLEN    = 32;

    // Op codes carried on the RS->ALU issue bus; anything not listed is a NOP.
    typedef enum logic [6:0] {
        ALU_NOP   = 7'd0,
        ALU_ADD   = 7'd1,
        ALU_SUB   = 7'd2,
        ALU_SLL   = 7'd3,
        ALU_SLT   = 7'd4,
        ALU_SLTU  = 7'd5,
        ALU_XOR   = 7'd6,
        ALU_SRL   = 7'd7,
        ALU_SRA   = 7'd8,
        ALU_OR    = 7'd9,
        ALU_AND   = 7'd10,
        ALU_ADDI  = 7'd11,
        ALU_SLTI  = 7'd12,
        ALU_SLTIU = 7'd13,
        ALU_XORI  = 7'd14,
        ALU_ORI   = 7'd15,
        ALU_ANDI  = 7'd16,
        ALU_SLLI  = 7'd17,
        ALU_SRLI  = 7'd18,
        ALU_SRAI  = 7'd19,
        ALU_LUI   = 7'd20,
        ALU_AUIPC = 7'd21,
        ALU_JAL   = 7'd22,
        ALU_JALR  = 7'd23,
        ALU_BEQ   = 7'd24,
        ALU_BNE   = 7'd25,
        ALU_BLT   = 7'd26,
        ALU_BGE   = 7'd27,
        ALU_BLTU  = 7'd28,
        ALU_BGEU  = 7'd29
    } alu_op_e;

    // Result of one op before it is registered onto the broadcast bus.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] val;
        logic            taken;
        logic [XLEN-1:0] target;
    } alu_result_t;

    // Register-register ops take their second operand from Vj, the rest from imm.
    function automatic logic is_reg_reg(input logic [6:0] op);
        return (op >= 7'(ALU_ADD)) && (op <= 7'(ALU_AND));
    endfunction

endpackage

// File: rtl/alu_exec_unit_core.sv
// Purely combinational ALU / branch-resolve core: value, taken flag, next PC.
module alu_exec_unit_core
    import alu_exec_unit_pkg::*;
(
    input  logic [6:0]      op,
    input  logic [XLEN-1:0] vi,
    input  logic [XLEN-1:0] vj,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    output alu_result_t     result
);

    logic [XLEN-1:0] opnd_b;
    logic [4:0]      shamt;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_plus_imm;
    logic [XLEN-1:0] jalr_sum;
    logic            lt_signed;
    logic            lt_unsigned;
    logic            cmp_eq;
    logic            cmp_lt;
    logic            cmp_ltu;

    assign opnd_b      = is_reg_reg(op) ? vj : imm;
    assign shamt       = opnd_b[4:0];
    assign pc_plus4    = pc + 32'd4;
    assign pc_plus_imm = pc + imm;
    assign jalr_sum    = vi + imm;
    assign lt_signed   = $signed(vi) < $signed(opnd_b);
    assign lt_unsigned = vi < opnd_b;
    assign cmp_eq      = vi == vj;
    assign cmp_lt      = $signed(vi) < $signed(vj);
    assign cmp_ltu     = vi < vj;

    // Decode the op and compute value, branch outcome and resolved next PC.
    always_comb begin
        result.valid  = 1'b1;
        result.val    = '0;
        result.taken  = 1'b0;
        result.target = pc_plus4;
        case (op)
            ALU_ADD, ALU_ADDI:  result.val = vi + opnd_b;
            ALU_SUB:            result.val = vi - vj;
            ALU_SLL, ALU_SLLI:  result.val = vi << shamt;
            ALU_SLT, ALU_SLTI:  result.val = {{(XLEN-1){1'b0}}, lt_signed};
            ALU_SLTU, ALU_SLTIU: result.val = {{(XLEN-1){1'b0}}, lt_unsigned};
            ALU_XOR, ALU_XORI:  result.val = vi ^ opnd_b;
            ALU_SRL, ALU_SRLI:  result.val = vi >> shamt;
            ALU_SRA, ALU_SRAI:  result.val = $signed(vi) >>> shamt;
            ALU_OR, ALU_ORI:    result.val = vi | opnd_b;
            ALU_AND, ALU_ANDI:  result.val = vi & opnd_b;
            ALU_LUI:            result.val = imm;
            ALU_AUIPC:          result.val = pc_plus_imm;
            ALU_JAL: begin
                result.val    = pc_plus4;
                result.taken  = 1'b1;
                result.target = pc_plus_imm;
            end
            ALU_JALR: begin
                result.val    = pc_plus4;
                result.taken  = 1'b1;
                result.target = {jalr_sum[XLEN-1:1], 1'b0};
            end
            ALU_BEQ:  result.taken = cmp_eq;
            ALU_BNE:  result.taken = !cmp_eq;
            ALU_BLT:  result.taken = cmp_lt;
            ALU_BGE:  result.taken = !cmp_lt;
            ALU_BLTU: result.taken = cmp_ltu;
            ALU_BGEU: result.taken = !cmp_ltu;
            default: begin
                result.valid  = 1'b0;
                result.target = '0;
            end
        endcase
        if (result.taken && op >= 7'(ALU_BEQ) && op <= 7'(ALU_BGEU)) begin
            result.target = pc_plus_imm;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Integer execute stage: registers the core result onto the ALU broadcast bus,
// with flush and global-ready gating.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               clear_flag,
    input  logic [6:0]         alu_op,
    input  logic [XLEN-1:0]    Vi,
    input  logic [XLEN-1:0]    Vj,
    input  logic [XLEN-1:0]    imm,
    input  logic [ROB_BIT-1:0] rd,
    input  logic [XLEN-1:0]    pc,
    output logic               rs_ready,
    output logic [ROB_BIT-1:0] rs_ROB_id,
    output logic [XLEN-1:0]    rs_val,
    output logic               br_taken,
    output logic [XLEN-1:0]    br_target
);

    alu_result_t core_result;

    alu_exec_unit_core u_core (
        .op     (alu_op),
        .vi     (Vi),
        .vj     (Vj),
        .imm    (imm),
        .pc     (pc),
        .result (core_result)
    );

    // Broadcast register: flush beats ready, a NOP or unknown op clears the bus.
    always_ff @(posedge clk_in) begin
        if (rst_in || clear_flag) begin
            rs_ready  <= 1'b0;
            rs_ROB_id <= '0;
            rs_val    <= '0;
            br_taken  <= 1'b0;
            br_target <= '0;
        end else if (rdy_in) begin
            if (core_result.valid) begin
                rs_ready  <= 1'b1;
                rs_ROB_id <= rd;
                rs_val    <= core_result.val;
                br_taken  <= core_result.taken;
                br_target <= core_result.target;
            end else begin
                rs_ready  <= 1'b0;
                rs_ROB_id <= '0;
                rs_val    <= '0;
                br_taken  <= 1'b0;
                br_target <= '0;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases with literal results
// followed by randomized traffic checked every cycle against a behavioural model.
module tb_alu_exec_unit;
    import alu_exec_unit_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear_flag;
    logic [6:0]  alu_op;
    logic [31:0] Vi;
    logic [31:0] Vj;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        rs_ready;
    logic [4:0]  rs_ROB_id;
    logic [31:0] rs_val;
    logic        br_taken;
    logic [31:0] br_target;

    int assertions = 0;
    int failures   = 0;
    bit check_en   = 1'b0;

    typedef struct packed {
        bit        ready;
        bit [4:0]  id;
        bit [31:0] val;
        bit        taken;
        bit [31:0] target;
    } bcast_t;

    bcast_t expected;
    bcast_t observed;

    alu_exec_unit dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .clear_flag (clear_flag),
        .alu_op     (alu_op),
        .Vi         (Vi),
        .Vj         (Vj),
        .imm        (imm),
        .rd         (rd),
        .pc         (pc),
        .rs_ready   (rs_ready),
        .rs_ROB_id  (rs_ROB_id),
        .rs_val     (rs_val),
        .br_taken   (br_taken),
        .br_target  (br_target)
    );

    always #5 clk_in = ~clk_in;

    assign observed = '{rs_ready, rs_ROB_id, rs_val, br_taken, br_target};

    // What one issued op must broadcast, straight from the instruction semantics.
    function automatic bcast_t model(input int op, input bit [31:0] a, input bit [31:0] b,
                                     input bit [31:0] i, input bit [31:0] p, input bit [4:0] tag);
        bcast_t r;
        bit [31:0] y;
        bit [31:0] fill;
        int sh;
        bit cond;
        r = '0;
        r.ready  = 1'b1;
        r.id     = tag;
        r.target = p + 4;
        y    = (op >= 1 && op <= 10) ? b : i;
        sh   = int'(y % 32);
        fill = 32'hFFFF_FFFF;
        cond = 1'b0;
        case (op)
            ALU_ADD, ALU_ADDI:   r.val = a + y;
            ALU_SUB:             r.val = a - b;
            ALU_SLL, ALU_SLLI:   r.val = a << sh;
            ALU_SLT, ALU_SLTI:   r.val = (int'(a) < int'(y)) ? 32'd1 : 32'd0;
            ALU_SLTU, ALU_SLTIU: r.val = (a < y) ? 32'd1 : 32'd0;
            ALU_XOR, ALU_XORI:   r.val = a ^ y;
            ALU_SRL, ALU_SRLI:   r.val = a >> sh;
            ALU_SRA, ALU_SRAI:   r.val = a[31] ? ((a >> sh) | ~(fill >> sh)) : (a >> sh);
            ALU_OR, ALU_ORI:     r.val = a | y;
            ALU_AND, ALU_ANDI:   r.val = a & y;
            ALU_LUI:             r.val = i;
            ALU_AUIPC:           r.val = p + i;
            ALU_JAL: begin
                r.val = p + 4; r.taken = 1'b1; r.target = p + i;
            end
            ALU_JALR: begin
                r.val = p + 4; r.taken = 1'b1; r.target = (a + i) - ((a + i) % 2);
            end
            ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU: begin
                case (op)
                    ALU_BEQ:  cond = (a == b);
                    ALU_BNE:  cond = (a != b);
                    ALU_BLT:  cond = (int'(a) < int'(b));
                    ALU_BGE:  cond = (int'(a) >= int'(b));
                    ALU_BLTU: cond = (a < b);
                    default:  cond = (a >= b);
                endcase
                r.taken  = cond;
                r.target = cond ? (p + i) : (p + 4);
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Reference state: mirrors what the bus must show after each edge.
    always @(posedge clk_in) begin
        if (rst_in || clear_flag)
            expected <= '0;
        else if (rdy_in)
            expected <= model(int'(alu_op), Vi, Vj, imm, pc, rd);
    end

    // Every-cycle comparison of the bus against the reference.
    always @(negedge clk_in) begin
        if (check_en) begin
            assertions++;
            if (observed !== expected) begin
                failures++;
                $display("[TB] FAIL cycle_compare t=%0t: got rdy=%0b id=%0d val=%h tk=%0b tgt=%h, need rdy=%0b id=%0d val=%h tk=%0b tgt=%h",
                         $time, rs_ready, rs_ROB_id, rs_val, br_taken, br_target,
                         expected.ready, expected.id, expected.val, expected.taken, expected.target);
            end
        end
    end

    task automatic applyStimulus(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] i, input logic [4:0] tag, input logic [31:0] p);
        @(posedge clk_in);
        #1;
        alu_op = op;
        Vi     = a;
        Vj     = b;
        imm    = i;
        rd     = tag;
        pc     = p;
    endtask

    task automatic checkOutput(input string name, input bit r, input bit [4:0] id, input bit [31:0] v,
                               input bit t, input bit [31:0] tg);
        bcast_t want;
        want = '{r, id, v, t, tg};
        assertions++;
        if (observed !== want) begin
            failures++;
            $display("[TB] FAIL %s: got rdy=%0b id=%0d val=%h tk=%0b tgt=%h, need rdy=%0b id=%0d val=%h tk=%0b tgt=%h",
                     name, rs_ready, rs_ROB_id, rs_val, br_taken, br_target, r, id, v, t, tg);
        end
        assertions++;
        if (expected !== want) begin
            failures++;
            $display("[TB] FAIL %s_model: model val=%h tgt=%h disagrees with literal val=%h tgt=%h",
                     name, expected.val, expected.target, v, tg);
        end
    endtask

    initial begin
        bit [31:0] r12;
        rst_in = 1'b1; rdy_in = 1'b1; clear_flag = 1'b0;
        alu_op = 7'd0; Vi = '0; Vj = '0; imm = '0; rd = '0; pc = '0;
        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        check_en = 1'b1;
        @(negedge clk_in);
        checkOutput("reset_state", 0, 0, 32'h0, 0, 32'h0);

        $display("[TB] basic add and one-cycle broadcast");
        applyStimulus(ALU_ADD, 32'd7, -32'sd3, 32'd0, 5'd4, 32'h0);
        applyStimulus(ALU_NOP, 32'd0, 32'd0, 32'd0, 5'd0, 32'h0);
        @(negedge clk_in);
        checkOutput("add", 1, 4, 32'd4, 0, 32'd4);
        @(negedge clk_in);
        checkOutput("add_single_pulse", 0, 0, 32'h0, 0, 32'h0);

        $display("[TB] back-to-back shift and compare");
        applyStimulus(ALU_SRA, 32'h8000_0000, 32'h24, 32'd0, 5'd5, 32'h200);
        applyStimulus(ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd6, 32'h204);
        @(negedge clk_in);
        checkOutput("sra_shamt", 1, 5, 32'hF800_0000, 0, 32'h204);
        applyStimulus(ALU_BLT, 32'hFFFF_FFFF, 32'd0, -32'sd8, 5'd7, 32'h100);
        @(negedge clk_in);
        checkOutput("sltu", 1, 6, 32'd1, 0, 32'h208);

        $display("[TB] branches and jumps");
        applyStimulus(ALU_BGEU, 32'hFFFF_FFFF, 32'd0, -32'sd8, 5'd8, 32'h100);
        @(negedge clk_in);
        checkOutput("blt_taken", 1, 7, 32'h0, 1, 32'hF8);
        applyStimulus(ALU_BLTU, 32'hFFFF_FFFF, 32'd0, -32'sd8, 5'd9, 32'h100);
        @(negedge clk_in);
        checkOutput("bgeu_taken", 1, 8, 32'h0, 1, 32'hF8);
        applyStimulus(ALU_JALR, 32'h1001, 32'd0, 32'd2, 5'd0, 32'h40);
        @(negedge clk_in);
        checkOutput("bltu_not_taken", 1, 9, 32'h0, 0, 32'h104);
        applyStimulus(ALU_JAL, 32'd0, 32'd0, 32'h20, 5'd3, 32'h1000);
        @(negedge clk_in);
        checkOutput("jalr_tag0", 1, 0, 32'h44, 1, 32'h1002);
        applyStimulus(ALU_LUI, 32'd0, 32'd0, 32'h1234_5000, 5'd2, 32'h10);
        @(negedge clk_in);
        checkOutput("jal", 1, 3, 32'h1004, 1, 32'h1020);
        applyStimulus(7'd100, 32'd5, 32'd6, 32'd7, 5'd9, 32'h500);
        @(negedge clk_in);
        checkOutput("lui", 1, 2, 32'h1234_5000, 0, 32'h14);
        applyStimulus(ALU_NOP, 32'd0, 32'd0, 32'd0, 5'd0, 32'h0);
        @(negedge clk_in);
        checkOutput("undefined_op", 0, 0, 32'h0, 0, 32'h0);

        // The flush is held across the rd=2 and rd=3 issue slots.
        $display("[TB] flush kills in-flight and same-cycle issue");
        applyStimulus(ALU_ADD, 32'd1, 32'd1, 32'd0, 5'd1, 32'h0);
        applyStimulus(ALU_ADD, 32'd2, 32'd2, 32'd0, 5'd2, 32'h0);
        clear_flag = 1'b1;
        @(negedge clk_in);
        checkOutput("flush_first_survives", 1, 1, 32'd2, 0, 32'd4);
        applyStimulus(ALU_ADD, 32'd3, 32'd3, 32'd0, 5'd3, 32'h0);
        @(negedge clk_in);
        checkOutput("flush_kills_rd2", 0, 0, 32'h0, 0, 32'h0);
        applyStimulus(ALU_NOP, 32'd0, 32'd0, 32'd0, 5'd0, 32'h0);
        clear_flag = 1'b0;
        @(negedge clk_in);
        checkOutput("flush_kills_rd3", 0, 0, 32'h0, 0, 32'h0);

        $display("[TB] ready stall and mid-stream reset");
        applyStimulus(ALU_XOR, 32'hF0F0, 32'h0FF0, 32'd0, 5'd10, 32'h300);
        applyStimulus(ALU_ADD, 32'd5, 32'd5, 32'd0, 5'd11, 32'h0);
        rdy_in = 1'b0;
        @(negedge clk_in);
        checkOutput("xor", 1, 10, 32'hFF00, 0, 32'h304);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            checkOutput("rdy_hold", 1, 10, 32'hFF00, 0, 32'h304);
        end
        rdy_in = 1'b1;
        @(negedge clk_in);
        checkOutput("rdy_resume", 1, 11, 32'd10, 0, 32'd4);
        applyStimulus(ALU_ADD, 32'd1, 32'd2, 32'd0, 5'd12, 32'h0);
        rst_in = 1'b1;
        @(negedge clk_in);
        checkOutput("pre_reset", 1, 11, 32'd10, 0, 32'd4);
        @(negedge clk_in);
        checkOutput("mid_reset", 0, 0, 32'h0, 0, 32'h0);
        rst_in = 1'b0;

        $display("[TB] randomized traffic");
        for (int n = 0; n < 600; n++) begin
            @(posedge clk_in);
            #1;
            alu_op     = ($urandom_range(0, 9) == 0) ? 7'd0 : 7'($urandom_range(1, 34));
            Vi         = $urandom;
            Vj         = ($urandom_range(0, 3) == 0) ? Vi : $urandom;
            r12        = $urandom;
            imm        = ($urandom_range(0, 1) == 0) ? {{20{r12[11]}}, r12[11:0]} : r12;
            rd         = 5'($urandom);
            pc         = $urandom & 32'hFFFF_FFFC;
            rdy_in     = ($urandom_range(0, 7) != 0);
            clear_flag = ($urandom_range(0, 19) == 0);
            rst_in     = ($urandom_range(0, 49) == 0);
        end
        @(posedge clk_in);
        #1;
        rst_in = 1'b0; clear_flag = 1'b0; rdy_in = 1'b1; alu_op = 7'd0;
        repeat (2) @(negedge clk_in);
        check_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
